// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among NREQ requesters.
// All outputs registered; one transfer in flight; ack is a one-cycle one-hot pulse.
module spi_master_arbiter #(
  parameter int BITS          = 28,
  parameter int NREQ          = 3,
  parameter int START_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*BITS-1:0]    req_data,
  output logic [NREQ-1:0]         ack,
  output logic [BITS-1:0]         rsp_data,
  output logic                    rsp_err,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic [NREQ-1:0]         ss_en,
  output logic                    busy,
  output logic [BITS-1:0]         m_data,
  output logic                    m_send,
  input  logic                    m_busy,
  input  logic [BITS-1:0]         m_rdata
);
  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [BITS-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0] ss_en_q, ss_en_d;
  logic            busy_q, busy_d;
  logic [BITS-1:0] m_data_q, m_data_d;
  logic            m_send_q, m_send_d;
  logic [SW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] req_eff;
  logic            gnt_vld;
  logic [SW-1:0]   gnt_idx;
  logic [SW-1:0]   cand;

  // ack_q is nonzero only in the IDLE cycle right after RESP, and only at
  // last_grant, so it doubles as the mask for the requester just served.
  always_comb begin
    req_eff = req & ~ack_q;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = SW'((int'(last_grant_q) + i) % NREQ);
      if (!gnt_vld && req_eff[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = '0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    sel_d        = sel_q;
    ss_en_d      = ss_en_q;
    m_data_d     = m_data_q;
    m_send_d     = 1'b0;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d          = ISSUE;
          m_data_d         = req_data[gnt_idx*BITS +: BITS];
          sel_d            = gnt_idx;
          ss_en_d          = '0;
          ss_en_d[gnt_idx] = 1'b1;
          last_grant_d     = gnt_idx;
          cnt_d            = '0;
          m_send_d         = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        if (m_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          state_d    = RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else begin
          m_send_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!m_busy) begin
          state_d    = RESP;
          rsp_data_d = m_rdata;
          rsp_err_d  = 1'b0;
        end
      end
      RESP: begin
        state_d      = IDLE;
        ack_d[sel_q] = 1'b1;
        ss_en_d      = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ack_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      sel_q        <= '0;
      ss_en_q      <= '0;
      busy_q       <= 1'b0;
      m_data_q     <= '0;
      m_send_q     <= 1'b0;
      last_grant_q <= SW'(NREQ - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      sel_q        <= sel_d;
      ss_en_q      <= ss_en_d;
      busy_q       <= busy_d;
      m_data_q     <= m_data_d;
      m_send_q     <= m_send_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ack      = ack_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign sel      = sel_q;
  assign ss_en    = ss_en_q;
  assign busy     = busy_q;
  assign m_data   = m_data_q;
  assign m_send   = m_send_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed requests, a behavioural SPI master,
// and a scoreboard queue checked by an independent monitor.
module tb_spi_master_arbiter;
  localparam int BITS = 28;
  localparam int NREQ = 3;
  localparam int SW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*BITS-1:0] req_data;
  logic [NREQ-1:0]      ack;
  logic [BITS-1:0]      rsp_data;
  logic                 rsp_err;
  logic [SW-1:0]        sel;
  logic [NREQ-1:0]      ss_en;
  logic                 busy;
  logic [BITS-1:0]      m_data;
  logic                 m_send;
  logic                 m_busy;
  logic [BITS-1:0]      m_rdata;

  spi_master_arbiter #(.BITS(BITS), .NREQ(NREQ), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .sel(sel), .ss_en(ss_en),
    .busy(busy), .m_data(m_data), .m_send(m_send), .m_busy(m_busy),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              idx;
    logic [BITS-1:0] mdata;
    logic [BITS-1:0] rdata;
    logic            err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [BITS-1:0] rdata_tab [NREQ];
  int              busy_len = 40;
  logic            m_mute   = 1'b0;
  logic [NREQ-1:0] hold_extra = '0;
  logic [NREQ-1:0] pend_drop  = '0;
  logic [NREQ-1:0] pend_rearm = '0;
  int              rearm [NREQ] = '{default: 0};

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(int idx, logic [BITS-1:0] md, logic [BITS-1:0] rd, logic err);
    exp_t e;
    e.idx = idx; e.mdata = md; e.rdata = rd; e.err = err;
    sb.push_back(e);
  endtask

  task automatic set_slice(int i, logic [BITS-1:0] v);
    req_data[i*BITS +: BITS] = v;
  endtask

  task automatic check_reset_vals(string p);
    check({p, "_ack"}, ack, 0);
    check({p, "_rsp_data"}, rsp_data, 0);
    check({p, "_rsp_err"}, rsp_err, 0);
    check({p, "_sel"}, sel, 0);
    check({p, "_ss_en"}, ss_en, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_m_data"}, m_data, 0);
    check({p, "_m_send"}, m_send, 0);
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, (sb.size() == 0 && !busy), 1);
  endtask

  task automatic wait_wait_done(string name, int budget);
    int n = 0;
    while (!(ss_en != '0 && m_busy && !m_send) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_in_wait_done"}, (ss_en != '0 && m_busy && !m_send), 1);
  endtask

  // Behavioural SPI master: busy for busy_len cycles after seeing send, the
  // addressed slave's reply appears on m_rdata as busy falls.
  initial begin
    m_busy  = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_send && !m_busy && !m_mute) begin
        m_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        m_rdata = rdata_tab[sel];
        m_busy  = 1'b0;
      end
    end
  end

  // Requester side: drop req after ack (optionally one cycle late), re-raise if asked.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          if (hold_extra[i]) pend_drop[i] = 1'b1;
          else begin
            req[i] = 1'b0;
            if (rearm[i] > 0) begin
              pend_rearm[i] = 1'b1;
              rearm[i]--;
            end
          end
        end else if (pend_drop[i]) begin
          req[i]       = 1'b0;
          pend_drop[i] = 1'b0;
        end else if (pend_rearm[i]) begin
          req[i]        = 1'b1;
          pend_rearm[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: checks the in-flight transfer and every ack against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ss_en != '0) begin
          check("ss_en_onehot", $countones(ss_en), 1);
          if (sb.size() > 0) begin
            check("ss_en_grant", ss_en, 1 << sb[0].idx);
            check("m_data_held", m_data, sb[0].mdata);
          end
        end
        if (ack != '0) begin
          if (sb.size() == 0) check("unexpected_ack", ack, 0);
          else begin
            e = sb.pop_front();
            check("ack_onehot", ack, 1 << e.idx);
            check("rsp_data", rsp_data, e.rdata);
            check("rsp_err", rsp_err, e.err);
            check("sel", sel, e.idx);
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) rdata_tab[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;
    @(negedge clk);

    // Single transfer from requester 0, long master busy time
    rdata_tab[0] = 28'h1234567;
    set_slice(0, 28'h0ABCDEF);
    push(0, 28'h0ABCDEF, 28'h1234567, 1'b0);
    req[0] = 1'b1;
    @(negedge clk);
    check("t1_send_latency", m_send, 1);
    check("t1_ss_en", ss_en, 3'b001);
    n = 0;
    while (!m_busy && n < 50) begin @(negedge clk); n++; end
    check("t1_busy_rise", m_busy, 1);
    n = 0;
    while (m_busy && n < 100) begin @(negedge clk); n++; end
    check("t1_busy_fall", m_busy, 0);
    @(negedge clk);
    check("t1_ack_not_early", ack, 0);
    @(negedge clk);
    check("t1_ack_timing", ack, 3'b001);
    wait_drain("t1", 50);

    // Fresh reset so round-robin starts after NREQ-1: all requesting -> 0,1,2,0
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst1");
    rst = 1'b0;
    busy_len = 5;
    for (int i = 0; i < NREQ; i++) begin
      rdata_tab[i] = BITS'(i + 1);
      set_slice(i, BITS'(28'h0A00000 + i));
    end
    push(0, 28'h0A00000, 28'h0000001, 1'b0);
    push(1, 28'h0A00001, 28'h0000002, 1'b0);
    push(2, 28'h0A00002, 28'h0000003, 1'b0);
    push(0, 28'h0A00000, 28'h0000001, 1'b0);
    rearm[0] = 1;
    req = 3'b111;
    wait_drain("t2", 400);

    // Start timeout: master never answers
    m_mute = 1'b1;
    set_slice(2, 28'h0555555);
    push(2, 28'h0555555, 28'h0000000, 1'b1);
    req[2] = 1'b1;
    @(negedge clk);
    n = 0;
    while (m_send && n < 40) begin @(negedge clk); n++; end
    check("t3_issue_cycles", n, 16);
    wait_drain("t3", 50);
    m_mute = 1'b0;

    // Requester 1 holds req an extra cycle after ack while 0 is pending
    hold_extra = 3'b010;
    set_slice(1, 28'h0111111);
    set_slice(0, 28'h0222222);
    push(1, 28'h0111111, 28'h0000002, 1'b0);
    req[1] = 1'b1;
    wait_wait_done("t4", 50);
    push(0, 28'h0222222, 28'h0000001, 1'b0);
    req[0] = 1'b1;
    wait_drain("t4", 200);
    hold_extra = '0;
    repeat (3) @(negedge clk);
    check("t4_no_dup_grant", busy, 0);

    // Reset in the middle of WAIT_DONE abandons the transfer without ack
    busy_len = 20;
    set_slice(1, 28'h0333333);
    push(1, 28'h0333333, 28'h0000002, 1'b0);
    req[1] = 1'b1;
    wait_wait_done("t5", 50);
    repeat (2) @(negedge clk);
    sb.delete();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check_reset_vals("t5_rst");
    rst = 1'b0;
    n = 0;
    while (m_busy && n < 50) begin @(negedge clk); n++; end
    check("t5_master_idle", m_busy, 0);
    push(1, 28'h0333333, 28'h0000002, 1'b0);
    req[1] = 1'b1;
    wait_drain("t5", 100);

    // Drop req and change req_data during WAIT_DONE: transfer still completes
    rdata_tab[0] = 28'h0BEEF01;
    set_slice(0, 28'h0C0FFEE);
    push(0, 28'h0C0FFEE, 28'h0BEEF01, 1'b0);
    req[0] = 1'b1;
    wait_wait_done("t6", 50);
    req[0] = 1'b0;
    set_slice(0, 28'h0DEAD00);
    wait_drain("t6", 100);
    check("t6_m_data_final", m_data, 28'h0C0FFEE);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_master_rtl instance among NREQ requesters.
- Arbitrates round-robin, presents the winner's frame to the master and pulses the master's send input.
- Tracks the master busy flag to completion and returns the received frame to the winner.
- Drives the slave-select index used by the MISO mux, and a one-hot slave-enable bus.

Parameters:
- BITS, 28: SPI frame width in bits.
- NREQ, 3: number of requesters (one per exe unit / slave).
- START_TIMEOUT, 16: cycles in ISSUE without m_busy rising before the transfer is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request level; held until matching ack
- req_data  in  NREQ*BITS  frame per requester; slice i = bits [i*BITS +: BITS]
- ack  out  NREQ  one-cycle completion pulse, one-hot
- rsp_data  out  BITS  received frame; valid while ack != 0
- rsp_err  out  1  valid with ack; 1 = start timeout, rsp_data = 0
- sel  out  $clog2(NREQ)  index of current or last granted requester (MISO mux select)
- ss_en  out  NREQ  one-hot enable of granted slave; 0 when not in a transfer
- busy  out  1  arbiter not in IDLE
- m_data  out  BITS  to master i_data
- m_send  out  1  to master i_send
- m_busy  in  1  from master o_busy
- m_rdata  in  BITS  from master o_data

Behaviour:
- All outputs are registered.
- Reset (any cycle, including mid-transfer):
  - state = IDLE; ack = 0; rsp_data = 0; rsp_err = 0; sel = 0; ss_en = 0; busy = 0; m_data = 0; m_send = 0; last_grant = NREQ-1; timeout counter = 0.
  - An in-flight master transfer is abandoned; no ack is issued for it.
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - If any unmasked req bit is set, grant the first set bit searching upward from last_grant+1, modulo NREQ.
  - On grant: latch req_data slice into m_data, set sel and ss_en, update last_grant, clear counter, go to ISSUE.
  - No req: stay in IDLE; m_send = 0.
- Mask: in the single IDLE cycle immediately following RESP, req[last_grant] is ignored. The requester must drop req no later than the cycle after ack.
- ISSUE:
  - m_send = 1; counter increments each cycle.
  - If m_busy = 1: deassert m_send next cycle, go to WAIT_DONE.
  - Else, if counter reaches START_TIMEOUT-1: go to RESP with rsp_err = 1 and rsp_data = 0.
- WAIT_DONE:
  - m_send = 0; m_data and ss_en held.
  - When m_busy = 0: capture m_rdata into rsp_data, rsp_err = 0, go to RESP.
  - No timeout in this state.
- RESP:
  - ack[sel] = 1 for exactly one cycle; ss_en = 0; go to IDLE.
  - sel keeps its value until the next grant.
- Latency:
  - Request first seen in IDLE at cycle t → m_send high at t+1.
  - ack is issued 2 cycles after the cycle in which m_busy is sampled low in WAIT_DONE.
- Request handling:
  - Deasserting req mid-transfer does not cancel the transfer; ack still issues.
  - req_data changes after grant are ignored.
  - At most one transfer is in flight; ack is always one-hot or zero.
- Round-robin fairness: with all NREQ requesting continuously, grant order is 0,1,2,0,1,2,… Starvation bound is NREQ-1 transfers.

Test Plan:
- Reset then req[0] with data 28'h0ABCDEF, master model busy for 40 cycles, returning 28'h1234567 → m_send pulses; ss_en = 001; ack[0] one cycle with rsp_data = 28'h1234567, rsp_err = 0; sel = 0.
- req = 111 held, slave i returns 28'h000000i+1 → grant order 0,1,2,0; each ack paired with the correct rsp_data; ss_en never multi-hot.
- req[2] only, master never raises m_busy → after 16 cycles in ISSUE: ack[2] = 1, rsp_err = 1, rsp_data = 0; arbiter returns to IDLE.
- req[1] held one extra cycle after ack[1] while req[0] is pending → next grant is 0, not a duplicate grant to 1.
- rst asserted during WAIT_DONE → next cycle all outputs at reset values, no ack; new req[1] afterwards completes normally.
- req[0] dropped during WAIT_DONE, req_data[0] changed → ack[0] still issues; m_data held at the originally latched value throughout.
